// File: rtl/pipe_mem_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package pipe_mem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {GRANT_IF = 1'b0, GRANT_MEM = 1'b1} grant_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_wait_counter.sv
// Access wait counter: loads LATENCY-1 on issue, counts down while busy, flags zero.
module mem_wait_counter
  import pipe_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between IF and MEM, alternating grants and
// latching finished results so a stalled stage is never re-issued.
module mem_port_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ok,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ok,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic              flush_wb
);
  state_t            r_state, w_state_nxt;
  grant_t            r_last_grant;
  logic              r_mem_done, r_if_done;
  logic [DATA_W-1:0] r_mem_hold, r_if_hold, r_acc_wdata;
  logic [ADDR_W-1:0] r_acc_addr;
  logic              r_acc_we;
  logic w_mreq, w_ireq, w_gnt_mem, w_gnt_if, w_issue, w_cnt_zero;
  logic w_complete, w_mem_ready, w_if_ready;

  assign w_mreq    = (mem_read | mem_write) & ~r_mem_done;
  assign w_ireq    = if_req & ~r_if_done;
  // MEM wins a tie unless it took the previous grant; nothing starts while in reset
  assign w_gnt_mem = ~rst & (r_state == IDLE) & w_mreq & (~w_ireq | (r_last_grant != GRANT_MEM));
  assign w_gnt_if  = ~rst & (r_state == IDLE) & w_ireq & ~w_gnt_mem;
  assign w_issue   = w_gnt_mem | w_gnt_if;

  assign w_complete  = (r_state == BUSY) & w_cnt_zero;
  assign w_mem_ready = w_complete & (r_last_grant == GRANT_MEM);
  assign w_if_ready  = w_complete & (r_last_grant == GRANT_IF);

  mem_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_issue),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .i_dec      (r_state == BUSY),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue)    w_state_nxt = BUSY;
      BUSY:    if (w_cnt_zero) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = (r_state == BUSY) & r_acc_we;
    m_addr  = r_acc_addr;
    m_wdata = r_acc_wdata;
    if (w_gnt_mem) begin
      m_en    = 1'b1;
      m_we    = mem_write;
      m_addr  = mem_addr;
      m_wdata = mem_wdata;
    end else if (w_gnt_if) begin
      m_en    = 1'b1;
      m_we    = 1'b0;
      m_addr  = if_addr;
      m_wdata = '0;
    end
  end

  assign mem_ok    = w_mem_ready | r_mem_done;
  assign if_ok     = w_if_ready  | r_if_done;
  assign mem_rdata = r_mem_done ? r_mem_hold : m_rdata;
  assign if_rdata  = r_if_done  ? r_if_hold  : m_rdata;
  assign stall     = ((mem_read | mem_write) & ~mem_ok) | (if_req & ~if_ok);
  assign flush_wb  = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GRANT_IF;
      r_acc_addr   <= '0;
      r_acc_we     <= 1'b0;
      r_acc_wdata  <= '0;
      r_mem_done   <= 1'b0;
      r_if_done    <= 1'b0;
      r_mem_hold   <= '0;
      r_if_hold    <= '0;
    end else begin
      if (w_issue) begin
        r_acc_addr   <= m_addr;
        r_acc_we     <= m_we;
        r_acc_wdata  <= m_wdata;
        r_last_grant <= w_gnt_mem ? GRANT_MEM : GRANT_IF;
      end
      // results survive only while the pipeline is frozen
      if (!stall) begin
        r_mem_done <= 1'b0;
        r_if_done  <= 1'b0;
      end else begin
        if (w_mem_ready) begin
          r_mem_done <= 1'b1;
          r_mem_hold <= m_rdata;
        end
        if (w_if_ready) begin
          r_if_done <= 1'b1;
          r_if_hold <= m_rdata;
        end
      end
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It sequences each access with a wait counter and alternates grants fairly. It latches completed results so a stalled stage is never re-issued. It drives the global `stall` that freezes PC, IF2ID, ID2EX and EX2MEM, and the `flush_wb` that loads a bubble into MEM2WB.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `LATENCY`, 2: memory read latency in cycles; legal range 1 to 15.

Ports:
- `clk`: input, 1 bit, clock.
- `rst`: input, 1 bit, reset, asynchronous, active-high.
- `if_req`: input, 1 bit, IF fetch request.
- `if_addr`: input, `ADDR_W`, fetch address (PC).
- `if_rdata`: output, `DATA_W`, fetched instruction.
- `if_ok`: output, 1 bit, fetch data valid this cycle.
- `mem_read`: input, 1 bit, EX2MEM load request.
- `mem_write`: input, 1 bit, EX2MEM store request.
- `mem_addr`: input, `ADDR_W`, EX2MEM ALUResult.
- `mem_wdata`: input, `DATA_W`, EX2MEM ReadDataRF1.
- `mem_rdata`: output, `DATA_W`, load data.
- `mem_ok`: output, 1 bit, MEM access complete this cycle.
- `m_en`: output, 1 bit, memory access start pulse.
- `m_we`: output, 1 bit, memory write enable.
- `m_addr`: output, `ADDR_W`, memory address.
- `m_wdata`: output, `DATA_W`, memory write data.
- `m_rdata`: input, `DATA_W`, memory read data, valid `LATENCY` cycles after `m_en`.
- `stall`: output, 1 bit, freeze PC, IF2ID, ID2EX and EX2MEM.
- `flush_wb`: output, 1 bit, load a bubble into MEM2WB; always equal to `stall`.

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight.
- Pending requests:
  - `mreq = (mem_read | mem_write) & ~mem_done`
  - `ireq = if_req & ~if_done`
- Grant rule in IDLE:
  - If only one request is pending, grant it.
  - If both are pending, grant MEM unless `last_grant == MEM`, then grant IF.
  - If neither is pending, stay in IDLE.
- Issue cycle, in IDLE when a grant is made:
  - `m_en = 1`.
  - `m_we = mem_write` for a MEM grant, 0 for an IF grant.
  - `m_addr` and `m_wdata` are taken directly from the granted requester.
  - Address, write enable and data are registered into `acc_*`; `cnt` is loaded with `LATENCY-1`; `last_grant` is updated; the state moves to BUSY.
- BUSY:
  - `m_en = 0`; `m_addr`, `m_we` and `m_wdata` come from `acc_*` and are held stable.
  - `cnt` decrements each cycle.
  - When `cnt == 0`, the access completes: the granted side's ready is asserted combinationally, with data taken from `m_rdata`, and the state returns to IDLE.
- Outputs:
  - `mem_ok = mem_ready | mem_done`.
  - `if_ok = if_ready | if_done`.
  - `mem_rdata = mem_done ? mem_hold : m_rdata`. `if_rdata` follows the same rule using `if_done` and `if_hold`.
- Done latches:
  - On a completion cycle with `stall == 1`: set `*_done` and capture `m_rdata` into `*_hold`.
  - When `stall == 0`: clear both done flags, because the pipeline advances.
- `stall = ((mem_read|mem_write) & ~mem_ok) | (if_req & ~if_ok)`. `flush_wb = stall`.
- Reset values:
  - state IDLE, `cnt = 0`, `last_grant = IF`, done flags 0, hold registers 0, `acc_*` 0.
  - Combinational outputs consequently: `m_en = 0`, `m_we = 0`, `if_ok = 0`, `mem_ok = 0`.
- Reset mid-access: the access is abandoned, no ready is produced, and the requester re-issues after reset.
- `mem_read` and `mem_write` must never be high together; if they are, treat the request as a write.

## Timing
- Issue in cycle t means ready in cycle t+LATENCY.
- Throughput is one access per LATENCY+1 cycles; the cycle after a completion is IDLE and may issue again.
- A lone request has no added latency: issue occurs in the same cycle the request appears.
- Load plus fetch with LATENCY=2:
  - `stall` is high in cycles 0–4 and low in cycle 5.
  - MEM completes in cycle 2; IF is issued in cycle 3 and completes in cycle 5.
- A store completes (`mem_ok`) in cycle t+LATENCY. `m_addr`, `m_wdata` and `m_we` are stable from t through t+LATENCY.
- `*_done` never remains set across an unstalled edge.

## Structure
- Shared package `pipe_mem_pkg` contains:
  - `state_t` {IDLE, BUSY}.
  - `grant_t` {GRANT_IF, GRANT_MEM}.
  - `CNT_W = 4`.
- Sub-module `mem_wait_counter` handles load, decrement and zero-detect, with async reset. Everything else stays in the top module.

## Test plan
1. Lone fetch, LATENCY=2: `if_req=1`, `if_addr=0x40`; memory returns 0x8C010004.
   - `m_en` is high in cycle 0.
   - In cycle 2, `if_ok=1` and `if_rdata=0x8C010004`.
   - `stall=1` in cycles 0–1 and `stall=0` in cycle 2.
2. Load plus fetch together in cycle 0: `mem_read=1`, `mem_addr=0x100`, memory data 0xDEADBEEF.
   - MEM is issued in cycle 0; `mem_done` is set in cycle 2.
   - IF is issued in cycle 3; `if_ok` in cycle 5.
   - `mem_rdata` reads 0xDEADBEEF in cycles 2–5.
   - Exactly two `m_en` pulses occur.
3. Store: `mem_write=1`, `mem_addr=0x20`, `mem_wdata=0x1234`.
   - `m_en=1` and `m_we=1` in cycle 0.
   - `m_addr=0x20` and `m_wdata=0x1234` in cycles 0–2.
   - `mem_ok` in cycle 2.
4. Fairness: `if_req` and `mem_read` held continuously across three instructions.
   - Grant order alternates MEM, IF, MEM, IF.
   - No request is issued twice within one stall window.
5. Reset mid-access: `rst` pulsed in cycle 1 of a load.
   - All outputs take their reset values; no `mem_ok` is produced.
   - The next `m_en` occurs in the first cycle after `rst` falls.
6. LATENCY=1: a lone fetch is issued in cycle 0 with `if_ok` in cycle 1; back-to-back fetches issue in cycles 0, 2, 4.
